// File: rtl/wb_timer_pkg.sv
// rtl/wb_timer_pkg.sv - register map, control bit indices and timer state encoding
package wb_timer_pkg;

  // Word addresses decoded from adr_i[2:0]
  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_PRESCALE = 3'd1;
  localparam logic [2:0] ADDR_RELOAD   = 3'd2;
  localparam logic [2:0] ADDR_COUNT    = 3'd3;
  localparam logic [2:0] ADDR_STATUS   = 3'd4;

  // CTRL and STATUS bit positions
  localparam int CTRL_EN        = 0;
  localparam int CTRL_IRQ_EN    = 1;
  localparam int CTRL_ONESHOT   = 2;
  localparam int STATUS_EXPIRED = 0;

  // IDLE: disabled, RUN: counting, HALT: one-shot expired and parked
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } timer_state_t;

endpackage

// File: rtl/wb_timer_core.sv
// rtl/wb_timer_core.sv - prescaler, down-counter and run/halt state machine
module wb_timer_core
  import wb_timer_pkg::*;
#(
  parameter int DAT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_wr,
  input  logic             en_wdata,
  input  logic             oneshot,
  input  logic [DAT_W-1:0] prescale,
  input  logic [DAT_W-1:0] reload,
  input  logic             cnt_wr,
  input  logic [DAT_W-1:0] cnt_wdata,
  input  logic             expired_clr,
  output logic             running,
  output logic             expire,
  output logic [DAT_W-1:0] count
);

  timer_state_t     state;
  logic [DAT_W-1:0] pre_cnt;
  logic             tick;
  logic             en_rise;

  // A fresh enable restarts the prescale period from zero
  assign en_rise = en_wr & en_wdata & ~running;

  // >= rather than == so that lowering PRESCALE mid-period ticks at once instead of wrapping
  assign tick = running & (pre_cnt >= prescale);

  // A COUNT write in the tick cycle replaces the tick's effect, including the expiry
  assign expire = tick & ~cnt_wr & (count == '0);

  // Run/halt state machine; EN is the registered running flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      running <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en_wr && en_wdata) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (en_wr) begin
            if (!en_wdata) begin
              state   <= ST_IDLE;
              running <= 1'b0;
            end
          end else if (expire && oneshot) begin
            state   <= ST_HALT;
            running <= 1'b0;
          end
        end
        ST_HALT: begin
          if (en_wr && en_wdata) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end else if (expired_clr) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  // Prescaler and down-counter; reload replaces the decrement below zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      count   <= '0;
    end else begin
      if (en_rise || tick) begin
        pre_cnt <= '0;
      end else if (running) begin
        pre_cnt <= pre_cnt + DAT_W'(1);
      end

      if (cnt_wr) begin
        count <= cnt_wdata;
      end else if (tick) begin
        count <= (count == '0) ? reload : count - DAT_W'(1);
      end
    end
  end

endmodule

// File: rtl/wb_timer.sv
// rtl/wb_timer.sv - Wishbone pipelined timer: bus decode and register file
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter int ADR_W = 16,
  parameter int DAT_W = 16
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_n_i,
  input  logic [ADR_W-1:0] adr_i,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic             we_i,
  input  logic [DAT_W-1:0] dat_i,
  output logic [DAT_W-1:0] dat_o,
  output logic             ack_o,
  output logic             stall_o,
  output logic             irq_o
);

  logic [2:0]       reg_adr;
  logic             req;
  logic             wr;
  logic             ctrl_wr;
  logic             prescale_wr;
  logic             reload_wr;
  logic             count_wr;
  logic             status_w1c;
  logic             unused_adr;

  logic             irq_en;
  logic             oneshot;
  logic [DAT_W-1:0] prescale;
  logic [DAT_W-1:0] reload;
  logic             expired;
  logic             irq_q;
  logic             ack_q;
  logic [DAT_W-1:0] rdata_q;
  logic [DAT_W-1:0] rdata;

  logic             running;
  logic             expire;
  logic [DAT_W-1:0] count;

  assign reg_adr    = adr_i[2:0];
  assign unused_adr = ^adr_i[ADR_W-1:3];

  assign req         = cyc_i & stb_i;
  assign wr          = req & we_i;
  assign ctrl_wr     = wr & (reg_adr == ADDR_CTRL);
  assign prescale_wr = wr & (reg_adr == ADDR_PRESCALE);
  assign reload_wr   = wr & (reg_adr == ADDR_RELOAD);
  assign count_wr    = wr & (reg_adr == ADDR_COUNT);
  assign status_w1c  = wr & (reg_adr == ADDR_STATUS) & dat_i[STATUS_EXPIRED];

  wb_timer_core #(
    .DAT_W (DAT_W)
  ) u_core (
    .clk         (sys_clk_i),
    .rst_n       (sys_rst_n_i),
    .en_wr       (ctrl_wr),
    .en_wdata    (dat_i[CTRL_EN]),
    .oneshot     (oneshot),
    .prescale    (prescale),
    .reload      (reload),
    .cnt_wr      (count_wr),
    .cnt_wdata   (dat_i),
    .expired_clr (status_w1c & ~expire),
    .running     (running),
    .expire      (expire),
    .count       (count)
  );

  // Register file; a new expiry beats a simultaneous write-1-to-clear
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      irq_en   <= 1'b0;
      oneshot  <= 1'b0;
      prescale <= '0;
      reload   <= '0;
      expired  <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        irq_en  <= dat_i[CTRL_IRQ_EN];
        oneshot <= dat_i[CTRL_ONESHOT];
      end
      if (prescale_wr) begin
        prescale <= dat_i;
      end
      if (reload_wr) begin
        reload <= dat_i;
      end
      if (expire) begin
        expired <= 1'b1;
      end else if (status_w1c) begin
        expired <= 1'b0;
      end
      irq_q <= expired & irq_en;
    end
  end

  // Read mux; unmapped addresses return zero
  always_comb begin
    rdata = '0;
    case (reg_adr)
      ADDR_CTRL: begin
        rdata[CTRL_EN]      = running;
        rdata[CTRL_IRQ_EN]  = irq_en;
        rdata[CTRL_ONESHOT] = oneshot;
      end
      ADDR_PRESCALE: rdata = prescale;
      ADDR_RELOAD:   rdata = reload;
      ADDR_COUNT:    rdata = count;
      ADDR_STATUS:   rdata[STATUS_EXPIRED] = expired;
      default:       rdata = '0;
    endcase
  end

  // Every accepted request is acked next cycle; only reads carry data
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= req;
      rdata_q <= (req && !we_i) ? rdata : '0;
    end
  end

  // Dropping cyc_i cancels the pending ack but not the side effects already taken
  assign ack_o   = ack_q & cyc_i;
  assign dat_o   = ack_o ? rdata_q : '0;
  assign stall_o = 1'b0;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_wb_timer.sv
// tb/tb_wb_timer.sv - scoreboard bench for wb_timer
module tb_wb_timer;

  localparam logic [2:0] A_CTRL = 3'd0;
  localparam logic [2:0] A_PRE  = 3'd1;
  localparam logic [2:0] A_REL  = 3'd2;
  localparam logic [2:0] A_CNT  = 3'd3;
  localparam logic [2:0] A_STAT = 3'd4;

  typedef struct {
    int          r;
    bit          bus;
    bit          we;
    logic [2:0]  adr;
    logic [15:0] dat;
    bit          ack_exp;
    logic [15:0] exp;
    bit          irq_chk;
    bit          irq_exp;
    bit          drop;
  } step_t;

  typedef struct {
    int          due;
    logic [15:0] data;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] adr = '0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [15:0] dat = '0;
  logic [15:0] dat_o;
  logic        ack_o;
  logic        stall_o;
  logic        irq_o;

  int    t = 0;
  int    n_checks = 0;
  int    n_errors = 0;
  bit    mon_on = 1'b0;
  step_t steps[$];
  sb_t   sb[$];

  wb_timer #(
    .ADR_W (16),
    .DAT_W (16)
  ) dut (
    .sys_clk_i   (clk),
    .sys_rst_n_i (rst_n),
    .adr_i       (adr),
    .cyc_i       (cyc),
    .stb_i       (stb),
    .we_i        (we),
    .dat_i       (dat),
    .dat_o       (dat_o),
    .ack_o       (ack_o),
    .stall_o     (stall_o),
    .irq_o       (irq_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) t <= t + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", tag, t, got, want);
    end
  endtask

  // Ack/data monitor: each expected ack must show up exactly in its due cycle
  always @(negedge clk) begin
    #1;
    if (mon_on) begin
      check("stall", stall_o, 0);
      if (sb.size() > 0 && sb[0].due == t) begin
        check("ack", ack_o, 1);
        check("ack_data", dat_o, sb[0].data);
        void'(sb.pop_front());
      end else begin
        check("idle_bus", {ack_o, dat_o}, 0);
      end
    end
  end

  task automatic add(input int r, input bit bus, input bit w, input logic [2:0] a,
                     input logic [15:0] d, input bit ack_exp, input logic [15:0] e,
                     input bit irq_chk, input bit irq_exp, input bit drop);
    step_t s;
    s.r = r; s.bus = bus; s.we = w; s.adr = a; s.dat = d; s.ack_exp = ack_exp;
    s.exp = e; s.irq_chk = irq_chk; s.irq_exp = irq_exp; s.drop = drop;
    steps.push_back(s);
  endtask

  task automatic rd(input int r, input logic [2:0] a, input logic [15:0] e);
    add(r, 1, 0, a, 16'h0, 1, e, 0, 0, 0);
  endtask
  task automatic rd_na(input int r, input logic [2:0] a);
    add(r, 1, 0, a, 16'h0, 0, 16'h0, 0, 0, 0);
  endtask
  task automatic wr(input int r, input logic [2:0] a, input logic [15:0] d);
    add(r, 1, 1, a, d, 1, 16'h0, 0, 0, 0);
  endtask
  task automatic wr_na(input int r, input logic [2:0] a, input logic [15:0] d);
    add(r, 1, 1, a, d, 0, 16'h0, 0, 0, 0);
  endtask
  task automatic irqc(input int r, input bit v);
    add(r, 0, 0, 3'd0, 16'h0, 0, 16'h0, 1, v, 0);
  endtask
  task automatic drop_cyc(input int r);
    add(r, 0, 0, 3'd0, 16'h0, 0, 16'h0, 0, 0, 1);
  endtask

  // Step r is driven in the cycle after edge base+r and accepted at edge base+r+1
  task automatic run_steps();
    int  base;
    sb_t e;
    base = t + 1;
    foreach (steps[i]) begin
      while (t - base < steps[i].r) begin
        stb = 1'b0; we = 1'b0;
        @(negedge clk);
      end
      if (steps[i].irq_chk) check("irq", irq_o, steps[i].irq_exp);
      if (steps[i].drop) begin
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
      end
      if (steps[i].bus) begin
        cyc = 1'b1; stb = 1'b1; we = steps[i].we;
        adr = {13'h0, steps[i].adr}; dat = steps[i].dat;
        if (steps[i].ack_exp) begin
          e.due  = t + 1;
          e.data = steps[i].we ? 16'h0 : steps[i].exp;
          sb.push_back(e);
        end
        @(negedge clk);
      end
    end
    stb = 1'b0; we = 1'b0; cyc = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("sb_drain", sb.size(), 0);
    sb.delete();
    steps.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_ack", ack_o, 0);
    check("reset_dat", dat_o, 0);
    check("reset_irq", irq_o, 0);
    check("reset_stall", stall_o, 0);
    rst_n = 1'b1;
    cyc = 1'b1;
    mon_on = 1'b1;

    // All mapped registers read zero after reset, acked back to back
    for (int i = 0; i < 5; i++) rd(i, 3'(i), 16'h0);
    run_steps();

    // Periodic mode: PRESCALE=3, RELOAD=2, COUNT=2 -> expiry every 12 cycles
    wr(0, A_PRE, 16'd3); wr(1, A_REL, 16'd2); wr(2, A_CNT, 16'd2); rd(3, A_CNT, 16'd2);
    run_steps();
    wr(-1, A_CTRL, 16'h3);
    irqc(11, 0); irqc(12, 0); irqc(13, 1);
    rd(13, A_CNT, 16'd2); rd(14, A_STAT, 16'h1); wr(15, A_STAT, 16'h1);
    irqc(16, 1); rd(16, A_CNT, 16'd1);
    irqc(17, 0); rd(17, A_STAT, 16'h0);
    rd(21, A_CNT, 16'd0); rd(22, A_STAT, 16'h0);
    irqc(23, 0); wr(23, A_STAT, 16'h1);
    irqc(24, 0); rd(24, A_STAT, 16'h1);
    irqc(25, 1); rd(25, A_CNT, 16'd2);
    wr(26, A_STAT, 16'h1);
    irqc(27, 1); rd(27, A_STAT, 16'h0);
    irqc(28, 0); rd(29, A_CTRL, 16'h3);
    run_steps();

    // One-shot: PRESCALE=0, COUNT=1 -> expiry at the second tick, then HALT
    wr(0, A_CTRL, 16'h0); wr(1, A_STAT, 16'h1); wr(2, A_PRE, 16'd0);
    wr(3, A_REL, 16'd5); wr(4, A_CNT, 16'd1); rd(5, A_REL, 16'd5); rd(6, A_CTRL, 16'h0);
    run_steps();
    wr(-1, A_CTRL, 16'h7);
    rd(0, A_CNT, 16'd1); rd(1, A_CNT, 16'd0);
    irqc(2, 0); rd(2, A_CNT, 16'd5);
    irqc(3, 1); rd(3, A_CTRL, 16'h6);
    rd(4, A_STAT, 16'h1); rd(6, A_CNT, 16'd5);
    wr(7, A_STAT, 16'h1);
    irqc(8, 1); rd(8, A_STAT, 16'h0);
    irqc(9, 0); rd(9, A_CTRL, 16'h6);
    run_steps();

    // Back-to-back reads, then the same burst with cyc_i dropped before the last ack
    rd(0, A_CNT, 16'd5); rd(1, A_CNT, 16'd5); rd(2, 3'd7, 16'h0); rd(3, A_REL, 16'd5);
    wr(4, 3'd5, 16'hffff);
    rd(5, A_CNT, 16'd5); rd(6, A_CNT, 16'd5); rd(7, 3'd7, 16'h0); rd_na(8, A_REL);
    drop_cyc(9);
    wr_na(11, A_REL, 16'd9); drop_cyc(12);
    rd(13, A_REL, 16'd9); rd(14, 3'd6, 16'h0);
    run_steps();

    // Reset while running with irq high and an ack pending
    wr(0, A_PRE, 16'd0); wr(1, A_REL, 16'd4); wr(2, A_CNT, 16'd0); wr(3, A_CTRL, 16'h3);
    run_steps();
    @(negedge clk);
    check("pre_irq", irq_o, 1);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {13'h0, A_CNT};
    @(posedge clk);
    #1;
    check("pend_ack", ack_o, 1);
    rst_n = 1'b0;
    #1;
    check("rst_ack", ack_o, 0);
    check("rst_irq", irq_o, 0);
    check("rst_dat", dat_o, 0);
    stb = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd(0, A_CNT, 16'd0); rd(1, A_CTRL, 16'h0); rd(2, A_STAT, 16'h0); rd(3, A_REL, 16'h0);
    irqc(3, 0);
    run_steps();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_timer.md
WB_TIMER -- requirements
Module: wb_timer

Interface
REQ-001 SHALL have parameter ADR_W, default 16, meaning Wishbone word-address width.
REQ-002 SHALL have parameter DAT_W, default 16, meaning Wishbone data and register width.
REQ-003 SHALL have port sys_clk_i, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port sys_rst_n_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port adr_i, input, ADR_W, word address; only adr_i[2:0] is decoded.
REQ-006 SHALL have port cyc_i, input, 1, bus cycle.
REQ-007 SHALL have port stb_i, input, 1, request strobe.
REQ-008 SHALL have port we_i, input, 1, write enable.
REQ-009 SHALL have port dat_i, input, DAT_W, write data.
REQ-010 SHALL have port dat_o, output, DAT_W, read data.
REQ-011 SHALL have port ack_o, output, 1, request acknowledge.
REQ-012 SHALL have port stall_o, output, 1, pipeline stall.
REQ-013 SHALL have port irq_o, output, 1, level interrupt.

Function
REQ-014 SHALL be a Wishbone B4 pipelined responder; stall_o SHALL be tied to 0.
REQ-015 SHALL accept a request in any cycle with cyc_i & stb_i.
REQ-016 SHALL assert ack_o exactly one cycle after acceptance, gated by cyc_i in that cycle; back-to-back requests get back-to-back acks.
REQ-017 SHALL present registered read data on dat_o only while ack_o=1, else dat_o=0; write acks also drive dat_o=0.
REQ-018 Register map SHALL be: 0 CTRL (bit0 EN, bit1 IRQ_EN, bit2 ONESHOT, RW); 1 PRESCALE (RW); 2 RELOAD (RW); 3 COUNT (read current, write loads); 4 STATUS (bit0 EXPIRED, write-1-to-clear). Addresses 5-7 read 0, writes ignored, still acked.
REQ-019 Prescaler SHALL count 0..PRESCALE while EN=1 and emit one-cycle tick when equal to PRESCALE, then return to 0; PRESCALE=0 ticks every cycle.
REQ-020 On tick with COUNT!=0, COUNT SHALL decrement by 1.
REQ-021 On tick with COUNT=0, COUNT SHALL load RELOAD, EXPIRED SHALL set; if ONESHOT=1, EN SHALL clear in the same cycle.
REQ-022 FSM SHALL have states IDLE (EN=0), RUN (EN=1), HALT (one-shot expired, EN=0); IDLE->RUN on EN write 1; RUN->IDLE on EN write 0; RUN->HALT on one-shot expiry; HALT->RUN on EN write 1; HALT->IDLE on EXPIRED clear.
REQ-023 Writing EN 0->1 SHALL clear the prescaler.
REQ-024 Write to COUNT coinciding with tick: write wins, prescaler clears.
REQ-025 STATUS W1C coinciding with expiry: set wins, EXPIRED stays 1.
REQ-026 irq_o SHALL be registered EXPIRED & IRQ_EN (one cycle after either changes).
REQ-027 Arithmetic SHALL be unsigned DAT_W-bit; no wrap below 0 (reload instead).
REQ-028 cyc_i deassertion SHALL drop a pending ack; register side effects of the accepted request SHALL still apply.

Reset
REQ-029 On sys_rst_n_i=0, asynchronously: all registers 0, FSM IDLE, prescaler 0, ack_o=0, dat_o=0, irq_o=0, stall_o=0.
REQ-030 Reset assertion mid-transaction SHALL abort it with no ack; first request after release SHALL be accepted normally.

Structure
REQ-031 Package wb_timer_pkg SHALL hold register address constants, CTRL bit indices and the FSM state enum.
REQ-032 Sub-module wb_timer_core SHALL hold prescaler, counter and FSM; wb_timer holds bus decode and register file.

Verification
REQ-033 Reset release, read addr 0-4 -> each acks next cycle with 0x0000; stall_o always 0.
REQ-034 PRESCALE=3, RELOAD=2, COUNT=2, CTRL=0x3 -> EXPIRED every 12 cycles, irq_o 1 cycle after first expiry, COUNT reloads 2.
REQ-035 CTRL=0x7, PRESCALE=0, COUNT=1 -> expiry at 2nd tick, EN reads 0, state HALT, COUNT=RELOAD held.
REQ-036 Write STATUS=0x1 in expiry cycle -> EXPIRED remains 1; next W1C clears it and irq_o drops one cycle later.
REQ-037 Four back-to-back reads (addr 3,3,7,2) -> four consecutive acks, addr 7 returns 0x0000; drop cyc_i after 3rd -> 4th ack suppressed.
REQ-038 Assert sys_rst_n_i low during running timer with pending ack -> ack_o, irq_o, COUNT go 0 immediately.
